lsu: RTL and testbench

Load/store unit: the initiator side of the word-addressed data-memory port. It accepts one RV32I load or store request at a time from the core and converts it into word accesses on the data-memory interface. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are performed as read-modify-write, because the memory port has no byte enables. It sits between the core's execute stage and `dmem`.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_lane.sv | 73 +++++++
 rtl/lsu.sv | 166 ++++++++++++++++
 tb/tb_lsu.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and request-classification helpers for the load/store unit.
// Funct3 codes, FSM state encoding, and misalignment/legality checks.
package lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    // Store codes share encodings with the loads, so they need their own type.
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Access size comes from funct3[1:0]; bit 2 only selects zero extension.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis_s;
        case (funct3[1:0])
            2'b01:   mis_s = addr_lo[0];
            2'b10:   mis_s = (addr_lo != 2'b00);
            default: mis_s = 1'b0;
        endcase
        return mis_s;
    endfunction

    function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
        logic ill_s;
        case (funct3)
            3'b000, 3'b001, 3'b010: ill_s = 1'b0;
            3'b100, 3'b101:         ill_s = write;
            default:                ill_s = 1'b1;
        endcase
        return ill_s;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extraction/extension and store merge
// for a little-endian word memory without byte enables.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_word,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half lanes of the memory word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'd0:    byte_s = mem_word[7:0];
            2'd1:    byte_s = mem_word[15:8];
            2'd2:    byte_s = mem_word[23:16];
            2'd3:    byte_s = mem_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = mem_word[31:16];
        end else begin
            half_s = mem_word[15:0];
        end
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            LB:      load_data = {{24{byte_s[7]}}, byte_s};
            LH:      load_data = {{16{half_s[15]}}, half_s};
            LW:      load_data = mem_word;
            LBU:     load_data = {24'h00_0000, byte_s};
            LHU:     load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Overlay the low byte/half of the store data onto the current word.
    always_comb begin
        store_word = mem_word;
        case (funct3)
            SB: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = store_data[7:0];
                    2'd1:    store_word[15:8]  = store_data[7:0];
                    2'd2:    store_word[23:16] = store_data[7:0];
                    2'd3:    store_word[31:24] = store_data[7:0];
                    default: store_word = mem_word;
                endcase
            end
            SH: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = store_data[15:0];
                end else begin
                    store_word[15:0] = store_data[15:0];
                end
            end
            SW:      store_word = store_data;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I request at a time, turned into word accesses;
// sub-word stores use read-modify-write since the memory has no byte enables.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_req_write,
    input  logic [2:0]      lsu_req_funct3,
    input  logic [XLEN-1:0] lsu_req_address,
    input  logic [XLEN-1:0] lsu_req_write_data,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_resp_read_data,
    output logic            lsu_resp_error,
    output logic            data_mem_write_enable,
    output logic [XLEN-1:0] data_mem_address,
    output logic [XLEN-1:0] data_mem_write_data,
    input  logic [XLEN-1:0] data_mem_read_data
);

    lsu_state_t      state_r;
    lsu_state_t      state_next_s;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] rdata_r;
    logic [XLEN-1:0] merged_r;
    logic            err_r;

    logic            accept_s;
    logic            bad_req_s;
    logic            sub_store_s;
    logic [XLEN-1:0] lane_load_s;
    logic [XLEN-1:0] lane_store_s;

    assign accept_s    = lsu_req_valid && (state_r == IDLE);
    assign bad_req_s   = is_illegal(lsu_req_write, lsu_req_funct3)
                      || is_misaligned(lsu_req_funct3, lsu_req_address[1:0]);
    assign sub_store_s = write_r && (funct3_r != SW);

    lsu_lane u_lane (
        .funct3     (funct3_r),
        .addr_lo    (addr_r[1:0]),
        .mem_word   (data_mem_read_data),
        .store_data (wdata_r),
        .load_data  (lane_load_s),
        .store_word (lane_store_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; bad requests skip memory entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bad_req_s) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = ACCESS;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (sub_store_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RESP;
                end
            end
            WRITE:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request capture and load result / merged word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            merged_r <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r  <= lsu_req_write;
                        funct3_r <= lsu_req_funct3;
                        addr_r   <= lsu_req_address;
                        wdata_r  <= lsu_req_write_data;
                        err_r    <= bad_req_s;
                        rdata_r  <= 32'h0000_0000;
                    end else begin
                        rdata_r  <= rdata_r;
                    end
                end
                ACCESS: begin
                    if (!write_r) begin
                        rdata_r <= lane_load_s;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    merged_r <= lane_store_s;
                end
                RESP: begin
                    rdata_r <= 32'h0000_0000;
                    err_r   <= 1'b0;
                end
                default: rdata_r <= rdata_r;
            endcase
        end
    end

    // Outputs decoded from state; the write strobe falls with an async reset.
    always_comb begin
        lsu_req_ready         = 1'b0;
        lsu_resp_valid        = 1'b0;
        lsu_resp_read_data    = 32'h0000_0000;
        lsu_resp_error        = 1'b0;
        data_mem_write_enable = 1'b0;
        data_mem_address      = 32'h0000_0000;
        data_mem_write_data   = 32'h0000_0000;
        case (state_r)
            IDLE: lsu_req_ready = 1'b1;
            ACCESS: begin
                data_mem_address = {addr_r[31:2], 2'b00};
                if (write_r && !sub_store_s) begin
                    data_mem_write_enable = 1'b1;
                    data_mem_write_data   = wdata_r;
                end else begin
                    data_mem_write_enable = 1'b0;
                    data_mem_write_data   = 32'h0000_0000;
                end
            end
            WRITE: begin
                data_mem_address      = {addr_r[31:2], 2'b00};
                data_mem_write_enable = 1'b1;
                data_mem_write_data   = merged_r;
            end
            RESP: begin
                lsu_resp_valid     = 1'b1;
                lsu_resp_read_data = rdata_r;
                lsu_resp_error     = err_r;
            end
            default: lsu_req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: a byte-array memory model predicts every response,
// its latency and each memory write; directed cases pin the model to literals.
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_write;
    logic [2:0]  lsu_req_funct3;
    logic [31:0] lsu_req_address;
    logic [31:0] lsu_req_write_data;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_read_data;
    logic        lsu_resp_error;
    logic        data_mem_write_enable;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_write_data;
    logic [31:0] data_mem_read_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] ram [0:255];
    bit          ram_init_done = 1'b0;
    logic [7:0]  mem_b [0:1023];
    bit          mb_init_done = 1'b0;

    lsu dut (
        .clk                   (clk),
        .reset                 (reset),
        .lsu_req_valid         (lsu_req_valid),
        .lsu_req_ready         (lsu_req_ready),
        .lsu_req_write         (lsu_req_write),
        .lsu_req_funct3        (lsu_req_funct3),
        .lsu_req_address       (lsu_req_address),
        .lsu_req_write_data    (lsu_req_write_data),
        .lsu_resp_valid        (lsu_resp_valid),
        .lsu_resp_read_data    (lsu_resp_read_data),
        .lsu_resp_error        (lsu_resp_error),
        .data_mem_write_enable (data_mem_write_enable),
        .data_mem_address      (data_mem_address),
        .data_mem_write_data   (data_mem_write_data),
        .data_mem_read_data    (data_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'hDEADBEEF;
        else if (i == 2) return 32'h11223344;
        else return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Environment memory: combinational read, write on the clock edge.
    assign data_mem_read_data = ram[data_mem_address[9:2]];
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else if (data_mem_write_enable) begin
            ram[data_mem_address[9:2]] <= data_mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state for the single outstanding request.
    bit          m_pend = 1'b0;
    int          m_resp_at, m_acc_edge, m_exp_strobes, m_addr, m_size;
    logic [31:0] m_exp_data, m_data, m_wword, m_waddr;
    logic        m_exp_err, m_store;
    int          strobes = 0;
    int          resp_count = 0;
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat, last_strobes;
    int          acc_q [$];
    logic [31:0] data_q [$];

    // Single compare process: checks DUT outputs against the model every cycle.
    always @(negedge clk) begin
        bit          pend_before, exp_valid, legal;
        int          lat, off, base;
        logic [31:0] v;
        logic [7:0]  b;
        if (!mb_init_done) begin
            for (int i = 0; i < 256; i++)
                for (int k = 0; k < 4; k++) mem_b[i*4+k] = 8'(init_word(i) >> (8*k));
            mb_init_done = 1'b1;
        end
        if (reset) begin
            m_pend = 1'b0;
            check("rst_ready", 32'(lsu_req_ready), 32'd1);
            check("rst_resp_valid", 32'(lsu_resp_valid), 32'd0);
            check("rst_we", 32'(data_mem_write_enable), 32'd0);
        end else begin
            pend_before = m_pend;
            exp_valid = m_pend && (cyc == m_resp_at);
            check("ready", 32'(lsu_req_ready), 32'(!pend_before));
            check("resp_valid", 32'(lsu_resp_valid), 32'(exp_valid));
            if (!pend_before) begin
                check("idle_we", 32'(data_mem_write_enable), 32'd0);
                check("idle_addr", data_mem_address, 32'd0);
                check("idle_wdata", data_mem_write_data, 32'd0);
            end
            if (data_mem_write_enable) begin
                strobes++;
                check("wr_addr", data_mem_address, m_waddr);
                check("wr_data", data_mem_write_data, m_wword);
            end
            if (exp_valid) begin
                check("resp_data", lsu_resp_read_data, m_exp_data);
                check("resp_error", 32'(lsu_resp_error), 32'(m_exp_err));
                check("wr_strobes", 32'(strobes), 32'(m_exp_strobes));
                if (m_store && !m_exp_err)
                    for (int k = 0; k < m_size; k++) mem_b[m_addr+k] = 8'(m_data >> (8*k));
                last_data    = lsu_resp_read_data;
                last_err     = lsu_resp_error;
                last_lat     = cyc - m_acc_edge + 1;
                last_strobes = strobes;
                data_q.push_back(lsu_resp_read_data);
                resp_count++;
                m_pend = 1'b0;
            end else begin
                check("nonresp_rdata", lsu_resp_read_data, 32'd0);
                if (pend_before && cyc >= m_resp_at) m_pend = 1'b0;
            end
            if (!pend_before && lsu_req_valid) begin
                m_size  = 1 << lsu_req_funct3[1:0];
                legal   = lsu_req_write ? (lsu_req_funct3 inside {3'd0, 3'd1, 3'd2})
                                        : (lsu_req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                m_exp_err = !legal || ((int'(lsu_req_address[2:0]) % m_size) != 0);
                m_store = lsu_req_write;
                m_addr  = int'(lsu_req_address[9:0]);
                m_data  = lsu_req_write_data;
                m_waddr = {lsu_req_address[31:2], 2'b00};
                v = 32'd0;
                if (!m_exp_err)
                    for (int k = 0; k < m_size; k++) v = v | (32'(mem_b[m_addr+k]) << (8*k));
                if (!lsu_req_funct3[2] && m_size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!lsu_req_funct3[2] && m_size == 2) v = {{16{v[15]}}, v[15:0]};
                m_exp_data = (m_store || m_exp_err) ? 32'd0 : v;
                base = m_addr & ~3;
                off  = m_addr & 3;
                m_wword = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    b = mem_b[base+k];
                    if (k >= off && k < off + m_size) b = 8'(m_data >> (8*(k-off)));
                    m_wword = m_wword | (32'(b) << (8*k));
                end
                m_exp_strobes = (m_exp_err || !m_store) ? 0 : 1;
                lat = m_exp_err ? 1 : ((m_store && m_size < 4) ? 3 : 2);
                m_acc_edge = cyc + 1;
                m_resp_at  = cyc + lat;
                strobes    = 0;
                acc_q.push_back(cyc + 1);
                m_pend = 1'b1;
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit wait_resp, input bit churn);
        int n;
        int rc0;
        int aq0;
        rc0 = resp_count;
        aq0 = acc_q.size();
        lsu_req_valid = 1'b1;
        lsu_req_write = w;
        lsu_req_funct3 = f3;
        lsu_req_address = a;
        lsu_req_write_data = d;
        n = 0;
        while (acc_q.size() == aq0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_accepted", 32'(acc_q.size() - aq0), 32'd1);
        if (churn) begin
            for (int c = 0; c < 2; c++) begin
                lsu_req_write = 1'($urandom_range(0, 1));
                lsu_req_funct3 = 3'($urandom_range(0, 7));
                lsu_req_address = 32'($urandom_range(0, 1023));
                lsu_req_write_data = $urandom;
                @(posedge clk); #1;
            end
        end
        lsu_req_valid = 1'b0;
        if (wait_resp) begin
            n = 0;
            while (resp_count == rc0 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            check("resp_seen", 32'(resp_count > rc0), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc0, aq0, n, mism;
        logic [31:0] a, w;
        reset = 1'b1;
        lsu_req_valid = 1'b0;
        lsu_req_write = 1'b0;
        lsu_req_funct3 = 3'b000;
        lsu_req_address = 32'd0;
        lsu_req_write_data = 32'd0;
        #22;
        check("reset_ready", 32'(lsu_req_ready), 32'd1);
        check("reset_resp_valid", 32'(lsu_resp_valid), 32'd0);
        check("reset_mem_addr", data_mem_address, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(1'b0, 3'b010, 32'h04, 32'd0, 1'b1, 1'b0);
        check("lw_data", last_data, 32'hDEADBEEF);
        check("lw_err", 32'(last_err), 32'd0);
        check("lw_latency", 32'(last_lat), 32'd2);
        do_req(1'b0, 3'b000, 32'h07, 32'd0, 1'b1, 1'b0);
        check("lb_data", last_data, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h07, 32'd0, 1'b1, 1'b0);
        check("lbu_data", last_data, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h06, 32'd0, 1'b1, 1'b0);
        check("lh_data", last_data, 32'hFFFFDEAD);
        do_req(1'b0, 3'b101, 32'h04, 32'd0, 1'b1, 1'b0);
        check("lhu_data", last_data, 32'h0000BEEF);

        do_req(1'b1, 3'b000, 32'h09, 32'h000000AA, 1'b1, 1'b0);
        check("sb_ram", ram[2], 32'h1122AA44);
        check("sb_latency", 32'(last_lat), 32'd3);
        check("sb_strobes", 32'(last_strobes), 32'd1);
        do_req(1'b1, 3'b001, 32'h0A, 32'h0000BEEF, 1'b1, 1'b0);
        check("sh_ram", ram[2], 32'hBEEFAA44);

        do_req(1'b1, 3'b010, 32'h0E, 32'h12345678, 1'b1, 1'b0);
        check("sw_mis_err", 32'(last_err), 32'd1);
        check("sw_mis_latency", 32'(last_lat), 32'd1);
        check("sw_mis_strobes", 32'(last_strobes), 32'd0);
        check("sw_mis_ram", ram[3], init_word(3));
        do_req(1'b0, 3'b011, 32'h00, 32'd0, 1'b1, 1'b0);
        check("illegal_err", 32'(last_err), 32'd1);
        check("illegal_data", last_data, 32'd0);

        // Reset while the SB is in its write cycle.
        rc0 = resp_count;
        do_req(1'b1, 3'b000, 32'h08, 32'h00000055, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rmw_we_in_write", 32'(data_mem_write_enable), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rmw_we_after_reset", 32'(data_mem_write_enable), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rmw_ready_after", 32'(lsu_req_ready), 32'd1);
        check("rmw_ram_unchanged", ram[2], 32'hBEEFAA44);
        check("rmw_no_resp", 32'(resp_count), 32'(rc0));
        @(posedge clk); #1;

        // Busy ignore: fields change while held valid.
        rc0 = resp_count;
        aq0 = acc_q.size();
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b0;
        lsu_req_funct3 = 3'b010;
        lsu_req_address = 32'h04;
        @(posedge clk); #1;
        lsu_req_write = 1'b1;
        lsu_req_funct3 = 3'b000;
        lsu_req_address = 32'h30;
        @(posedge clk); #1;
        lsu_req_write = 1'b0;
        lsu_req_funct3 = 3'b100;
        lsu_req_address = 32'h07;
        n = 0;
        while (acc_q.size() < aq0 + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lsu_req_valid = 1'b0;
        n = 0;
        while (resp_count < rc0 + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_resp_count", 32'(resp_count - rc0), 32'd2);
        if (data_q.size() >= rc0 + 2 && acc_q.size() >= aq0 + 2) begin
            check("busy_first_data", data_q[rc0], 32'hDEADBEEF);
            check("busy_second_data", data_q[rc0+1], 32'h000000DE);
            check("busy_accept_gap", 32'(acc_q[aq0+1] - acc_q[aq0]), 32'd3);
        end else begin
            check("busy_queues", 32'(data_q.size()), 32'(rc0 + 2));
        end

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:10] = 22'd0;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            w = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, w, 1'b1,
                   ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (10) @(posedge clk);
        #1;

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            w = {mem_b[i*4+3], mem_b[i*4+2], mem_b[i*4+1], mem_b[i*4]};
            if (ram[i] !== w) mism++;
        end
        check("final_mem_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
